// File: rtl/stream_splitter.sv
// stream_splitter: routes whole packets from one tagged stream to per-id register slices, discarding and counting packets with an unknown id.
module stream_splitter #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int T_ID_WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [T_QOS_WIDTH-1:0]    s_qos_i,
    input  logic [T_ID_WIDTH-1:0]     s_id_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [T_DATA_WIDTH-1:0]   m_data_o [STREAM_COUNT],
    output logic [T_QOS_WIDTH-1:0]    m_qos_o [STREAM_COUNT],
    output logic [STREAM_COUNT-1:0]   m_last_o,
    output logic [STREAM_COUNT-1:0]   m_valid_o,
    input  logic [STREAM_COUNT-1:0]   m_ready_i,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
    state_t                    r_state, w_state_nxt;
    logic [T_ID_WIDTH-1:0]     r_dst, w_dst_nxt, w_sel;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic [STREAM_COUNT-1:0]   w_free;
    logic                      w_id_ok, w_ready, w_acc, w_load, w_drop_inc;
    assign w_free     = ~m_valid_o | m_ready_i;
    assign w_id_ok    = 32'(s_id_i) < 32'(STREAM_COUNT);
    assign w_ready    = (r_state == BUSY) ? w_free[r_dst] :
                        (r_state == DROP || !w_id_ok) ? 1'b1 : w_free[s_id_i];
    assign s_ready_o  = rst_n && w_ready;
    assign w_acc      = s_valid_i && s_ready_o;
    assign w_sel      = (r_state == BUSY) ? r_dst : s_id_i;
    assign w_load     = w_acc && (r_state == BUSY || (r_state == IDLE && w_id_ok));
    assign w_drop_inc = w_acc && r_state == IDLE && !w_id_ok;
    assign drop_cnt_o = r_drop_cnt;
    always_comb begin
        w_state_nxt = r_state;
        w_dst_nxt   = r_dst;
        if (w_acc) begin
            if (s_last_i) begin
                w_state_nxt = IDLE;
            end else if (r_state == IDLE) begin
                w_state_nxt = w_id_ok ? BUSY : DROP;
                if (w_id_ok) w_dst_nxt = s_id_i;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dst      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dst   <= w_dst_nxt;
            if (w_drop_inc && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
    // A loading slice takes the new beat even while its old beat drains the same cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STREAM_COUNT; k++) begin
            if (!rst_n) begin
                m_valid_o[k] <= 1'b0;
                m_last_o[k]  <= 1'b0;
                m_data_o[k]  <= '0;
                m_qos_o[k]   <= '0;
            end else if (w_load && w_sel == T_ID_WIDTH'(k)) begin
                m_valid_o[k] <= 1'b1;
                m_last_o[k]  <= s_last_i;
                m_data_o[k]  <= s_data_i;
                m_qos_o[k]   <= s_qos_i;
            end else if (m_ready_i[k]) begin
                m_valid_o[k] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_splitter.sv
// tb_stream_splitter: directed checks of packet routing, back-pressure, drops, reset and counter saturation.
module tb_stream_splitter;
    logic       clk, rst_n;
    logic [7:0] s_data;
    logic [3:0] s_qos;
    logic [1:0] s_id;
    logic       s_last, s_valid;
    logic       s_ready_b, s_ready_a;
    logic [7:0] m_data_b [3];
    logic [3:0] m_qos_b [3];
    logic [2:0] m_last_b, m_valid_b, m_ready_b;
    logic [1:0] drop_b;
    logic [7:0] m_data_a [2];
    logic [3:0] m_qos_a [2];
    logic [1:0] m_last_a, m_valid_a, m_ready_a;
    logic [15:0] drop_a;
    int n_checks = 0;
    int n_errors = 0;

    stream_splitter #(.STREAM_COUNT(3), .DROP_CNT_WIDTH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id),
        .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready_b),
        .m_data_o(m_data_b), .m_qos_o(m_qos_b), .m_last_o(m_last_b), .m_valid_o(m_valid_b),
        .m_ready_i(m_ready_b), .drop_cnt_o(drop_b)
    );

    stream_splitter u_a (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id[0]),
        .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready_a),
        .m_data_o(m_data_a), .m_qos_o(m_qos_a), .m_last_o(m_last_a), .m_valid_o(m_valid_a),
        .m_ready_i(m_ready_a), .drop_cnt_o(drop_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] id, input logic [7:0] data, input logic last);
        s_id    = id;
        s_data  = data;
        s_qos   = data[3:0];
        s_last  = last;
        s_valid = 1'b1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        s_valid = 0; s_data = 0; s_qos = 0; s_id = 0; s_last = 0;
        m_ready_b = 3'b111; m_ready_a = 2'b11; rst_n = 0;
        tick(); tick();
        check("rst_valid", 32'(m_valid_b), 0);
        check("rst_drop", 32'(drop_b), 0);
        check("rst_ready", 32'(s_ready_b), 0);
        check("rst_data1", 32'(m_data_b[1]), 0);
        rst_n = 1;
        // Basic routing on both the 3-stream and 2-stream instances
        beat(1, 8'hA1, 0); #1 check("t1_ready", 32'(s_ready_b), 1); tick();
        check("t1_v_a1", 32'(m_valid_b), 3'b010);
        check("t1_d_a1", 32'(m_data_b[1]), 8'hA1);
        check("t1_q_a1", 32'(m_qos_b[1]), 4'h1);
        check("t1_l_a1", 32'(m_last_b[1]), 0);
        check("t1_sc2_v_a1", 32'(m_valid_a), 2'b10);
        check("t1_sc2_d_a1", 32'(m_data_a[1]), 8'hA1);
        beat(1, 8'hA2, 0); tick();
        check("t1_v_a2", 32'(m_valid_b), 3'b010);
        check("t1_d_a2", 32'(m_data_b[1]), 8'hA2);
        beat(1, 8'hA3, 1); tick();
        check("t1_v_a3", 32'(m_valid_b), 3'b010);
        check("t1_d_a3", 32'(m_data_b[1]), 8'hA3);
        check("t1_l_a3", 32'(m_last_b[1]), 1);
        beat(0, 8'hB0, 1); tick();
        check("t1_v_b0", 32'(m_valid_b), 3'b001);
        check("t1_d_b0", 32'(m_data_b[0]), 8'hB0);
        check("t1_l_b0", 32'(m_last_b[0]), 1);
        check("t1_sc2_v_b0", 32'(m_valid_a), 2'b01);
        check("t1_sc2_d_b0", 32'(m_data_a[0]), 8'hB0);
        idle(); tick();
        check("t1_drained", 32'(m_valid_b), 0);
        // Back-to-back single-beat packets to the same stream
        beat(2, 8'hC0, 1); tick();
        check("b2b_d_c0", 32'(m_data_b[2]), 8'hC0);
        beat(2, 8'hC1, 1); #1 check("b2b_ready", 32'(s_ready_b), 1); tick();
        check("b2b_v_c1", 32'(m_valid_b), 3'b100);
        check("b2b_d_c1", 32'(m_data_b[2]), 8'hC1);
        idle(); tick();
        // Back-pressure on stream 1 mid-packet
        beat(1, 8'hD1, 0); tick();
        m_ready_b[1] = 1'b0;
        beat(1, 8'hD2, 0);
        for (int i = 0; i < 4; i++) begin
            #1 check("t2_stall_ready", 32'(s_ready_b), 0);
            tick();
            check("t2_hold_d", 32'(m_data_b[1]), 8'hD1);
            check("t2_hold_v", 32'(m_valid_b), 3'b010);
        end
        m_ready_b[1] = 1'b1;
        #1 check("t2_resume_ready", 32'(s_ready_b), 1); tick();
        check("t2_d_d2", 32'(m_data_b[1]), 8'hD2);
        beat(1, 8'hD3, 1); tick();
        check("t2_d_d3", 32'(m_data_b[1]), 8'hD3);
        check("t2_l_d3", 32'(m_last_b[1]), 1);
        check("t2_v_d3", 32'(m_valid_b), 3'b010);
        idle(); tick();
        check("t2_drained", 32'(m_valid_b), 0);
        // Mid-packet id change stays on the locked stream
        beat(1, 8'hE1, 0); tick();
        check("t3_d_e1", 32'(m_data_b[1]), 8'hE1);
        beat(0, 8'hE2, 0); #1 check("t3_ready", 32'(s_ready_b), 1); tick();
        check("t3_v_e2", 32'(m_valid_b), 3'b010);
        check("t3_d_e2", 32'(m_data_b[1]), 8'hE2);
        beat(0, 8'hE3, 1); tick();
        check("t3_v_e3", 32'(m_valid_b), 3'b010);
        check("t3_d_e3", 32'(m_data_b[1]), 8'hE3);
        check("t3_l_e3", 32'(m_last_b[1]), 1);
        idle(); tick();
        // Drop of a packet with a non-existent id
        check("t4_drop_pre", 32'(drop_b), 0);
        beat(3, 8'hF1, 0); #1 check("t4_ready_f1", 32'(s_ready_b), 1); tick();
        check("t4_v_f1", 32'(m_valid_b), 0);
        check("t4_drop_f1", 32'(drop_b), 1);
        beat(3, 8'hF2, 1); #1 check("t4_ready_f2", 32'(s_ready_b), 1); tick();
        check("t4_v_f2", 32'(m_valid_b), 0);
        check("t4_drop_f2", 32'(drop_b), 1);
        beat(2, 8'h55, 1); tick();
        check("t4_v_55", 32'(m_valid_b), 3'b100);
        check("t4_d_55", 32'(m_data_b[2]), 8'h55);
        check("t4_drop_55", 32'(drop_b), 1);
        idle(); tick();
        // Reset in the middle of a stalled packet
        m_ready_b[1] = 1'b0;
        beat(1, 8'h61, 0); tick();
        check("t5_v_g1", 32'(m_valid_b), 3'b010);
        beat(1, 8'h62, 0);
        rst_n = 0;
        #1 check("t5_rst_ready", 32'(s_ready_b), 0); tick();
        check("t5_rst_valid", 32'(m_valid_b), 0);
        check("t5_rst_drop", 32'(drop_b), 0);
        rst_n = 1;
        m_ready_b = 3'b111;
        beat(2, 8'h62, 0); #1 check("t5_ready_g2", 32'(s_ready_b), 1); tick();
        check("t5_v_g2", 32'(m_valid_b), 3'b100);
        check("t5_d_g2", 32'(m_data_b[2]), 8'h62);
        beat(1, 8'h63, 1); tick();
        check("t5_v_g3", 32'(m_valid_b), 3'b100);
        check("t5_d_g3", 32'(m_data_b[2]), 8'h63);
        check("t5_l_g3", 32'(m_last_b[2]), 1);
        idle(); tick();
        // Saturation of the 2-bit drop counter
        for (int i = 0; i < 5; i++) begin
            beat(3, 8'(i), 1); tick();
            check("t6_drop", 32'(drop_b), (i < 3) ? i + 1 : 3);
            check("t6_valid", 32'(m_valid_b), 0);
        end
        idle(); tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
